double_ne_checker: RTL and testbench

- Synthesizable response-side checker for the `double_ne` comparator; the consuming end of the stimulus/response stream that drives `double_ne`.
- Captures each `(a, b)` stimulus and computes the IEEE-754 not-equal result independently.
- Delays that result to match DUT latency, compares it with the DUT's `z`, and keeps pass/fail status, counters and a first-mismatch record.
- Sits beside `double_ne` in on-chip self-test and simulation harnesses; replaces file-dumped result comparison.

---
 rtl/double_pkg.sv | 28 ++
 rtl/double_ne_ref.sv | 22 ++
 rtl/double_ne_checker.sv | 157 +++++++++++++++
 tb/tb_double_ne_checker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/double_pkg.sv
// Shared IEEE-754 binary64 field layout, special-value constants and checker
// state encoding for the double comparator checkers.
package double_pkg;

    localparam int SIGN_BIT = 63;
    localparam int EXP_MSB  = 62;
    localparam int EXP_LSB  = 52;
    localparam int MAN_MSB  = 51;
    localparam int MAN_LSB  = 0;

    localparam logic [10:0] EXP_ALL_ONES = 11'h7FF;

    localparam logic [63:0] POS_ZERO = 64'h0000_0000_0000_0000;
    localparam logic [63:0] NEG_ZERO = 64'h8000_0000_0000_0000;
    localparam logic [63:0] POS_INF  = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] QNAN     = 64'h7FF8_0000_0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FAILED = 2'd2
    } state_e;

    function automatic logic is_nan(input logic [63:0] v);
        return (v[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (v[MAN_MSB:MAN_LSB] != '0);
    endfunction

endpackage

// File: rtl/double_ne_ref.sv
// Combinational IEEE-754 binary64 not-equal reference: NaN is unequal to
// everything, +0 and -0 compare equal, otherwise bit patterns decide.
module double_ne_ref
    import double_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        z
);

    always_comb begin
        z = 1'b0;
        if (is_nan(a) || is_nan(b)) begin
            z = 1'b1;
        end else if ((a[SIGN_BIT-1:0] == '0) && (b[SIGN_BIT-1:0] == '0)) begin
            z = 1'b0;
        end else begin
            z = (a != b);
        end
    end

endmodule

// File: rtl/double_ne_checker.sv
// Response-side checker for double_ne: recomputes the expected result, delays it
// by the DUT latency and compares, keeping counters and a first-mismatch record.
module double_ne_checker
    import double_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             stim_valid,
    input  logic [63:0]      stim_a,
    input  logic [63:0]      stim_b,
    input  logic             dut_z,
    output logic [CNT_W-1:0] checked_count,
    output logic [CNT_W-1:0] mismatch_count,
    output logic             fail,
    output logic             busy,
    output logic [63:0]      first_a,
    output logic [63:0]      first_b,
    output logic             first_exp,
    output logic             first_got
);

    localparam int TAIL = LATENCY - 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic ref_z;

    double_ne_ref u_ref (
        .a (stim_a),
        .b (stim_b),
        .z (ref_z)
    );

    state_e             state_q, state_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] exp_q, exp_d;
    logic [63:0]        a_q [LATENCY];
    logic [63:0]        a_d [LATENCY];
    logic [63:0]        b_q [LATENCY];
    logic [63:0]        b_d [LATENCY];
    logic [CNT_W-1:0]   checked_q, checked_d;
    logic [CNT_W-1:0]   mismatch_q, mismatch_d;
    logic [63:0]        first_a_q, first_a_d;
    logic [63:0]        first_b_q, first_b_d;
    logic               first_exp_q, first_exp_d;
    logic               first_got_q, first_got_d;
    logic               cmp_en;
    logic               mism;

    always_comb begin
        cmp_en      = vld_q[TAIL] && !clear;
        mism        = cmp_en && (exp_q[TAIL] != dut_z);
        state_d     = state_q;
        checked_d   = checked_q;
        mismatch_d  = mismatch_q;
        first_a_d   = first_a_q;
        first_b_d   = first_b_q;
        first_exp_d = first_exp_q;
        first_got_d = first_got_q;

        vld_d[0] = stim_valid;
        exp_d[0] = ref_z;
        a_d[0]   = stim_a;
        b_d[0]   = stim_b;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            exp_d[i] = exp_q[i-1];
            a_d[i]   = a_q[i-1];
            b_d[i]   = b_q[i-1];
        end

        if (cmp_en) begin
            checked_d = checked_q + CNT_ONE;
        end
        if (mism && (mismatch_q != '1)) begin
            mismatch_d = mismatch_q + CNT_ONE;
        end

        // Only the transition into FAILED latches the record, so it stays frozen.
        unique case (state_q)
            IDLE, RUN: begin
                if (mism) begin
                    state_d     = FAILED;
                    first_a_d   = a_q[TAIL];
                    first_b_d   = b_q[TAIL];
                    first_exp_d = exp_q[TAIL];
                    first_got_d = dut_z;
                end else if (stim_valid) begin
                    state_d = RUN;
                end
            end
            FAILED:  state_d = FAILED;
            default: state_d = IDLE;
        endcase

        if (clear) begin
            state_d     = IDLE;
            vld_d       = '0;
            exp_d       = '0;
            checked_d   = '0;
            mismatch_d  = '0;
            first_a_d   = '0;
            first_b_d   = '0;
            first_exp_d = 1'b0;
            first_got_d = 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                a_d[i] = '0;
                b_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vld_q       <= '0;
            exp_q       <= '0;
            checked_q   <= '0;
            mismatch_q  <= '0;
            first_a_q   <= '0;
            first_b_q   <= '0;
            first_exp_q <= 1'b0;
            first_got_q <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            exp_q       <= exp_d;
            checked_q   <= checked_d;
            mismatch_q  <= mismatch_d;
            first_a_q   <= first_a_d;
            first_b_q   <= first_b_d;
            first_exp_q <= first_exp_d;
            first_got_q <= first_got_d;
            for (int i = 0; i < LATENCY; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
            end
        end
    end

    assign checked_count  = checked_q;
    assign mismatch_count = mismatch_q;
    assign fail           = (state_q == FAILED);
    assign busy           = |vld_q;
    assign first_a        = first_a_q;
    assign first_b        = first_b_q;
    assign first_exp      = first_exp_q;
    assign first_got      = first_got_q;

endmodule

// File: tb/tb_double_ne_checker.sv
// Bench for double_ne_checker: a LATENCY=1 and a LATENCY=3 instance share the
// stimulus; each phase resets both and checks one against a sample-level model.
module tb_double_ne_checker;
    import double_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        stim_valid = 1'b0;
    logic [63:0] stim_a = '0;
    logic [63:0] stim_b = '0;
    logic        dut_z = 1'b0;

    logic [31:0] cc1, mc1, cc3, mc3;
    logic        fail1, busy1, fe1, fg1, fail3, busy3, fe3, fg3;
    logic [63:0] fa1, fb1, fa3, fb3;

    always #5 clk = ~clk;

    double_ne_checker #(.LATENCY(1), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst), .clear(clear), .stim_valid(stim_valid),
        .stim_a(stim_a), .stim_b(stim_b), .dut_z(dut_z),
        .checked_count(cc1), .mismatch_count(mc1), .fail(fail1), .busy(busy1),
        .first_a(fa1), .first_b(fb1), .first_exp(fe1), .first_got(fg1)
    );

    double_ne_checker #(.LATENCY(3), .CNT_W(32)) dut3 (
        .clk(clk), .rst(rst), .clear(clear), .stim_valid(stim_valid),
        .stim_a(stim_a), .stim_b(stim_b), .dut_z(dut_z),
        .checked_count(cc3), .mismatch_count(mc3), .fail(fail3), .busy(busy3),
        .first_a(fa3), .first_b(fb3), .first_exp(fe3), .first_got(fg3)
    );

    int checks = 0;
    int errors = 0;

    // Sample-level model of what the checker should report.
    int          m_checked, m_mm;
    bit          m_fail;
    logic [63:0] m_fa, m_fb;
    logic        m_fe, m_fg;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        exp;
    } vec_t;

    vec_t tbl[12];

    function automatic logic ref_ne(input logic [63:0] a, input logic [63:0] b);
        logic na, nb;
        na = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
        nb = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
        if (na || nb) return 1'b1;
        if (((a << 1) == 64'd0) && ((b << 1) == 64'd0)) return 1'b0;
        return a != b;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic z, input logic c);
        stim_valid = v;
        stim_a     = a;
        stim_b     = b;
        dut_z      = z;
        clear      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stim_valid = 1'b0;
        clear = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic model_reset();
        m_checked = 0; m_mm = 0; m_fail = 0;
        m_fa = '0; m_fb = '0; m_fe = 1'b0; m_fg = 1'b0;
    endtask

    task automatic gen(output logic [63:0] a, output logic [63:0] b);
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 6))
            0: begin a = r; b = {$urandom, $urandom}; end
            1: begin a = r; b = r; end
            2: begin a = {r[63], 63'd0}; b = {$urandom_range(0, 1) == 1, 63'd0}; end
            3: begin a = {r[63], 11'h7FF, r[51:1], 1'b1}; b = ($urandom_range(0, 1) == 1) ? a : r; end
            4: begin a = {r[63], 11'h7FF, 52'd0}; b = {r[0], 11'h7FF, 52'd0}; end
            5: begin a = r; b = r ^ 64'h8000_0000_0000_0000; end
            default: begin a = r; b = r ^ (64'd1 << $urandom_range(0, 63)); end
        endcase
    endtask

    // Back-to-back samples with dut_z supplied L edges later; optional error
    // injection at given sample indices or at random.
    task automatic stream(input int L, input int n, input int bad1, input int bad2,
                          input bit rnd_bad, input bit busy_chk);
        logic zq[$];
        logic [63:0] a, b;
        logic e, flip, z;
        bit v;
        for (int c = 0; c < n + L; c++) begin
            v = (c < n);
            if (v) begin
                gen(a, b);
                e = ref_ne(a, b);
                flip = (c == bad1) || (c == bad2) || (rnd_bad && ($urandom_range(0, 9) == 0));
                zq.push_back(e ^ flip);
                m_checked++;
                if (flip) begin
                    m_mm++;
                    if (!m_fail) begin
                        m_fail = 1; m_fa = a; m_fb = b; m_fe = e; m_fg = e ^ flip;
                    end
                end
            end else begin
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
            end
            z = (c >= L) ? zq.pop_front() : logic'($urandom_range(0, 1));
            cyc(v, a, b, z, 1'b0);
            if (busy_chk && c == n + L - 2) chk("busy_before_drain", (L == 3) ? busy3 : busy1, 1);
            if (busy_chk && c == n + L - 1) chk("busy_after_drain", (L == 3) ? busy3 : busy1, 0);
        end
    endtask

    task automatic chk_model(input bit use3);
        chk("checked_count",  use3 ? cc3 : cc1,   m_checked);
        chk("mismatch_count", use3 ? mc3 : mc1,   m_mm);
        chk("fail",           use3 ? fail3 : fail1, m_fail);
        chk("first_a",        use3 ? fa3 : fa1,   m_fa);
        chk("first_b",        use3 ? fb3 : fb1,   m_fb);
        chk("first_exp",      use3 ? fe3 : fe1,   m_fe);
        chk("first_got",      use3 ? fg3 : fg1,   m_fg);
    endtask

    initial begin
        tbl[0]  = '{64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b1};
        tbl[1]  = '{64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b0};
        tbl[2]  = '{POS_ZERO, NEG_ZERO, 1'b0};
        tbl[3]  = '{NEG_ZERO, NEG_ZERO, 1'b0};
        tbl[4]  = '{POS_INF, POS_INF, 1'b0};
        tbl[5]  = '{POS_INF, 64'hFFF0_0000_0000_0000, 1'b1};
        tbl[6]  = '{QNAN, QNAN, 1'b1};
        tbl[7]  = '{QNAN, 64'h3FF0_0000_0000_0000, 1'b1};
        tbl[8]  = '{64'h3FF0_0000_0000_0000, 64'h7FF0_0000_0000_0001, 1'b1};
        tbl[9]  = '{64'h7FF0_0000_0000_0001, 64'h7FF0_0000_0000_0001, 1'b1};
        tbl[10] = '{64'h0000_0000_0000_0001, POS_ZERO, 1'b1};
        tbl[11] = '{64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0};

        @(posedge clk);
        #1;
        do_reset();
        model_reset();
        chk_model(0);
        chk("reset_busy1", busy1, 0);
        chk("reset_busy3", busy3, 0);
        chk("reset_checked3", cc3, 0);

        // LATENCY=1 directed: 1.0 vs 2.0 correct, then +0/-0 with wrong z.
        cyc(1, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 0, 0);
        cyc(1, POS_ZERO, NEG_ZERO, 1, 0);
        chk("dir_checked1", cc1, 1);
        chk("dir_mm1", mc1, 0);
        chk("dir_fail1", fail1, 0);
        cyc(0, 0, 0, 1, 0);
        m_checked = 2; m_mm = 1; m_fail = 1; m_fa = POS_ZERO; m_fb = NEG_ZERO; m_fe = 0; m_fg = 1;
        chk_model(0);

        do_reset();
        model_reset();
        cyc(1, QNAN, QNAN, 0, 0);
        cyc(1, POS_INF, POS_INF, 1, 0);
        cyc(0, 0, 0, 0, 0);
        m_checked = 2;
        chk_model(0);

        // Table vectors through the LATENCY=1 instance, correct z each time.
        do_reset();
        for (int i = 0; i <= 12; i++) begin
            cyc(i < 12, (i < 12) ? tbl[i % 12].a : 64'd0, (i < 12) ? tbl[i % 12].b : 64'd0,
                (i > 0) ? tbl[(i + 11) % 12].exp : 1'b0, 0);
            if (i > 0) chk($sformatf("tbl_mm_%0d", i - 1), mc1, 0);
        end
        chk("tbl_checked", cc1, 12);

        // LATENCY=3: 100 back-to-back correct samples and drain timing of busy.
        do_reset();
        model_reset();
        stream(3, 100, -1, -1, 0, 1);
        chk_model(1);

        // Mismatches at samples 5 and 9, then clear with a same-edge sample.
        do_reset();
        model_reset();
        stream(3, 20, 5, 9, 0, 0);
        chk_model(1);
        cyc(1, QNAN, POS_ZERO, 0, 1);
        model_reset();
        chk_model(1);
        chk("clear_busy", busy3, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, i[0], 0);
        chk("clear_sample_dropped", cc3, 0);
        chk("clear_idle_nofail", fail3, 0);

        // Clear on the very edge a compare would happen.
        cyc(1, POS_INF, POS_ZERO, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("clear_cmp_dropped", cc3, 0);
        chk("clear_cmp_nofail", fail3, 0);

        // Randomized streams with random error injection on both instances.
        do_reset();
        model_reset();
        stream(3, 300, -1, -1, 1, 0);
        chk_model(1);
        do_reset();
        model_reset();
        stream(1, 200, -1, -1, 1, 0);
        chk_model(0);

        // rst with two samples in flight; later dut_z toggles must be ignored.
        do_reset();
        cyc(1, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 0, 0);
        cyc(1, QNAN, QNAN, 0, 0);
        chk("inflight_busy", busy3, 1);
        rst = 1'b1;
        cyc(0, 0, 0, 1, 0);
        rst = 1'b0;
        chk("rst_checked", cc3, 0);
        chk("rst_busy", busy3, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, ~i[0], 0);
        model_reset();
        chk_model(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
